// File: rtl/mem_bank_ctrl.sv
// mem_bank_ctrl: single-port synchronous memory bank behind a valid/ready
// request handshake. Features per-byte write enables, a programmable number
// of wait states between accept and response, and out-of-range error
// reporting. After reset a hardware sweep clears every word before any
// request is accepted.
module mem_bank_ctrl #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [WIDTH/8-1:0]    be_i,
    input  logic                  wr_rd_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  err_o,
    output logic                  init_done_o
);

    localparam int NBYTES = WIDTH / 8;

    // Bits needed to index the implemented words. This is never less than 1,
    // so a single-word bank still has a legal index.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Depth in one extra bit, so the range compare also works when
    // DEPTH == 2**ADDR_WIDTH. In that case the compare is constant true.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // Wait counter preload. It is only used when WAIT_CYCLES > 0.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Control state
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic [3:0]            r_wait_cnt;

    // Captured request
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]      r_wdata;
    logic [NBYTES-1:0]     r_be;
    logic                  r_wr;

    // Registered outputs
    logic                  r_ready;
    logic                  r_err;
    logic [WIDTH-1:0]      r_rdata;
    logic                  r_init_done;

    // Storage
    logic [WIDTH-1:0]      r_mem [DEPTH];

    // Request seen by the response logic. In IDLE with zero wait states the
    // response is formed on the same edge that accepts the request, so the
    // live inputs are used. In every other case the captured copy is used.
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic                  w_req_wr;
    logic                  w_req_in_range;
    logic                  w_resp_in_range;
    logic [WIDTH-1:0]      w_rd_word;
    logic                  w_enter_resp;

    // Memory write port
    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_mem_addr;
    logic [WIDTH-1:0]      w_mem_wdata;
    logic [NBYTES-1:0]     w_mem_be;

    assign w_req_addr      = (r_state == ST_IDLE) ? addr_i  : r_addr;
    assign w_req_wr        = (r_state == ST_IDLE) ? wr_rd_i : r_wr;
    assign w_req_in_range  = ({1'b0, w_req_addr} < DEPTH_EXT);
    assign w_resp_in_range = ({1'b0, r_addr} < DEPTH_EXT);
    assign w_rd_word       = w_req_in_range ? r_mem[w_req_addr[IDX_W-1:0]] : '0;

    // Enter RESP on this edge. This happens either straight from IDLE when
    // there are no wait states, or at the end of the WAIT countdown.
    assign w_enter_resp = ((r_state == ST_IDLE) && valid_i && (WAIT_CYCLES == 0)) ||
                          ((r_state == ST_WAIT) && (r_wait_cnt == 4'd0));

    // Select the memory write source: the zero-fill sweep during INIT, or the
    // in-range part of a captured write during RESP.
    always_comb begin
        // NOTE: every signal gets a default before the case. Any path that
        // leaves a signal unassigned would otherwise infer a latch.
        w_mem_we    = 1'b0;
        w_mem_addr  = r_addr[IDX_W-1:0];
        w_mem_wdata = r_wdata;
        w_mem_be    = r_be;
        case (r_state)
            ST_INIT: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_init_cnt[IDX_W-1:0];
                w_mem_wdata = '0;
                w_mem_be    = '1;
            end
            ST_RESP: begin
                w_mem_we = r_wr && w_resp_in_range;
            end
            default: ;
        endcase
    end

    // Byte-masked storage write. The init sweep supplies the "reset" of the
    // contents.
    always_ff @(posedge clk_i) begin
        // NOTE: the array has no reset branch. An async reset on every word
        // would block RAM inference, and the init sweep clears it anyway.
        for (int b = 0; b < NBYTES; b++) begin
            if (w_mem_we && w_mem_be[b]) begin
                r_mem[w_mem_addr][8*b +: 8] <= w_mem_wdata[8*b +: 8];
            end
        end
    end

    // Control FSM with registered handshake, error and read-data outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_wr        <= 1'b0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_init_done <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments only, so
            // every read in this block sees the value from before the edge.
            // ready/err are single-cycle strobes; they are low unless RESP is
            // being entered on this edge.
            r_ready <= 1'b0;
            r_err   <= 1'b0;

            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == LAST_ADDR) begin
                        r_state     <= ST_IDLE;
                        r_init_done <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
                    end
                end

                ST_IDLE: begin
                    if (valid_i) begin
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_be    <= be_i;
                        r_wr    <= wr_rd_i;
                        if (WAIT_CYCLES > 0) begin
                            r_state    <= ST_WAIT;
                            r_wait_cnt <= WAIT_LOAD;
                        end else begin
                            r_state <= ST_RESP;
                        end
                    end
                end

                ST_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end

                ST_RESP: begin
                    // A captured write commits on this edge through the
                    // memory write port, before the next IDLE can sample a
                    // read.
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_INIT;
            endcase

            // The response is registered on entry to RESP. A read loads
            // rdata; a write leaves it holding the last read value.
            if (w_enter_resp) begin
                r_ready <= 1'b1;
                r_err   <= !w_req_in_range;
                if (!w_req_wr) begin
                    r_rdata <= w_rd_word;
                end
            end
        end
    end

    assign ready_o     = r_ready;
    assign err_o       = r_err;
    assign rdata_o     = r_rdata;
    assign init_done_o = r_init_done;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Testbench for mem_bank_ctrl. It runs three configurations side by side:
//   0: DEPTH=256, WAIT_CYCLES=1
//   1: DEPTH=200, WAIT_CYCLES=0
//   2: DEPTH=200, WAIT_CYCLES=3
// Expected responses come from a word-array model of the bank. They are queued
// when a request is issued and compared by an independent monitor process
// whenever ready_o strobes.
module tb_mem_bank_ctrl;

    localparam int NDUT = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst       [NDUT];
    logic [7:0]  addr      [NDUT];
    logic [31:0] wdata     [NDUT];
    logic [3:0]  be        [NDUT];
    logic        wr        [NDUT];
    logic        valid     [NDUT];
    logic        ready     [NDUT];
    logic [31:0] rdata     [NDUT];
    logic        err       [NDUT];
    logic        init_done [NDUT];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: the word contents and the last read value per bank.
    logic [31:0] model_mem [NDUT][256];
    logic [31:0] model_rd  [NDUT];

    // Scoreboard and monitor bookkeeping
    exp_t        sb_q       [NDUT][$];
    logic        prev_rdy   [NDUT];
    int          last_rdy   [NDUT];
    bit          spacing_on [NDUT];

    function automatic int depth_of(int d);
        return (d == 0) ? 256 : 200;
    endfunction

    function automatic int wait_of(int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    mem_bank_ctrl #(.WIDTH(32), .DEPTH(256), .ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .addr_i(addr[0]), .wdata_i(wdata[0]), .be_i(be[0]),
        .wr_rd_i(wr[0]), .valid_i(valid[0]), .ready_o(ready[0]), .rdata_o(rdata[0]),
        .err_o(err[0]), .init_done_o(init_done[0])
    );

    mem_bank_ctrl #(.WIDTH(32), .DEPTH(200), .ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .addr_i(addr[1]), .wdata_i(wdata[1]), .be_i(be[1]),
        .wr_rd_i(wr[1]), .valid_i(valid[1]), .ready_o(ready[1]), .rdata_o(rdata[1]),
        .err_o(err[1]), .init_done_o(init_done[1])
    );

    mem_bank_ctrl #(.WIDTH(32), .DEPTH(200), .ADDR_WIDTH(8), .WAIT_CYCLES(3)) u_dut2 (
        .clk_i(clk), .rst_i(rst[2]), .addr_i(addr[2]), .wdata_i(wdata[2]), .be_i(be[2]),
        .wr_rd_i(wr[2]), .valid_i(valid[2]), .ready_o(ready[2]), .rdata_o(rdata[2]),
        .err_o(err[2]), .init_done_o(init_done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected response per ready_o strobe. It also checks
    // pulse width, the spacing of back-to-back strobes, and that err_o stays
    // low outside response cycles.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (ready[d]) begin
                exp_t e;
                check($sformatf("ready_width_d%0d", d), prev_rdy[d], 1'b0);
                if (sb_q[d].size() == 0) begin
                    check($sformatf("unexpected_ready_d%0d", d), ready[d], 1'b0);
                end else begin
                    e = sb_q[d].pop_front();
                    check($sformatf("rdata_d%0d", d), rdata[d], e.rdata);
                    check($sformatf("err_d%0d", d), err[d], e.err);
                end
                if (spacing_on[d] && last_rdy[d] >= 0) begin
                    check($sformatf("ready_spacing_d%0d", d), cyc - last_rdy[d], wait_of(d) + 2);
                end
                last_rdy[d] = cyc;
            end else begin
                check($sformatf("err_idle_d%0d", d), err[d], 1'b0);
            end
            prev_rdy[d] = ready[d];
        end
    end

    // Issue one request from an IDLE negedge. Update the model, queue the
    // expected response, and wait (bounded) for ready_o. The task returns at
    // the next negedge, which is the IDLE cycle after the response.
    task automatic do_req(input int d, input bit w, input logic [7:0] a,
                          input logic [31:0] wd, input logic [3:0] b,
                          input bit hold, input bit drop);
        exp_t e;
        bit   in_r;
        int   n;
        in_r = int'(a) < depth_of(d);
        if (w) begin
            if (in_r) begin
                for (int k = 0; k < 4; k++) begin
                    if (b[k]) model_mem[d][a][8*k +: 8] = wd[8*k +: 8];
                end
            end
            e.rdata = model_rd[d];
        end else begin
            e.rdata = in_r ? model_mem[d][a] : 32'h0;
            model_rd[d] = e.rdata;
        end
        e.err = !in_r;
        sb_q[d].push_back(e);

        addr[d]  = a;
        wdata[d] = wd;
        be[d]    = b;
        wr[d]    = w;
        valid[d] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (drop) valid[d] = 1'b0;
        end while (!ready[d] && n < 64);
        check($sformatf("latency_d%0d", d), n, wait_of(d) + 1);
        @(negedge clk);
        if (!hold) valid[d] = 1'b0;
    endtask

    // Check reset values while rst is high, release it with valid held, and
    // confirm the init sweep length and silence. Then read 0x10, which the
    // held request turns into the first transaction.
    task automatic init_check(input int d);
        int  k;
        int  rise;
        bit  saw_rdy;
        wr[d]    = 1'b0;
        addr[d]  = 8'h10;
        wdata[d] = 32'h0;
        be[d]    = 4'h0;
        valid[d] = 1'b1;
        @(negedge clk);
        check($sformatf("rst_ready_d%0d", d), ready[d], 1'b0);
        check($sformatf("rst_err_d%0d", d), err[d], 1'b0);
        check($sformatf("rst_rdata_d%0d", d), rdata[d], 32'h0);
        check($sformatf("rst_init_done_d%0d", d), init_done[d], 1'b0);
        for (int i = 0; i < 256; i++) model_mem[d][i] = 32'h0;
        model_rd[d] = 32'h0;
        rst[d] = 1'b0;
        k = 0;
        rise = -1;
        saw_rdy = 1'b0;
        while (rise < 0 && k < depth_of(d) + 8) begin
            @(negedge clk);
            k++;
            if (ready[d]) saw_rdy = 1'b1;
            if (init_done[d]) rise = k;
        end
        check($sformatf("init_done_cycle_d%0d", d), rise, depth_of(d));
        check($sformatf("init_no_ready_d%0d", d), saw_rdy, 1'b0);
        do_req(d, 1'b0, 8'h10, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    // Back-to-back reads with valid held. The monitor checks the
    // WAIT_CYCLES+2 spacing.
    task automatic b2b_reads(input int d, input int n);
        spacing_on[d] = 1'b1;
        last_rdy[d]   = -1;
        for (int i = 0; i < n; i++) begin
            do_req(d, 1'b0, 8'(i * 3), 32'h0, 4'h0, (i < n - 1), 1'b0);
        end
        spacing_on[d] = 1'b0;
    endtask

    task automatic random_traffic(input int d, input int n);
        logic [7:0] a;
        bit         w;
        bit         hold;
        bit         drop;
        for (int i = 0; i < n; i++) begin
            a    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 215)) : 8'($urandom_range(0, 15));
            w    = $urandom_range(0, 1) == 1;
            drop = (wait_of(d) > 0) && ($urandom_range(0, 7) == 0);
            hold = !drop && (i < n - 1) && ($urandom_range(0, 1) == 1);
            do_req(d, w, a, $urandom, 4'($urandom_range(0, 15)), hold, drop);
        end
    endtask

    // Abort a write during WAIT with a mid-operation reset. It must not
    // respond and must not commit.
    task automatic reset_mid(input int d);
        bit saw_rdy;
        addr[d]  = 8'h03;
        wdata[d] = 32'hFFFF_FFFF;
        be[d]    = 4'hF;
        wr[d]    = 1'b1;
        valid[d] = 1'b1;
        @(negedge clk);
        rst[d] = 1'b1;
        saw_rdy = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ready[d]) saw_rdy = 1'b1;
        end
        check($sformatf("rstmid_no_ready_d%0d", d), saw_rdy, 1'b0);
        check($sformatf("rstmid_init_done_d%0d", d), init_done[d], 1'b0);
        init_check(d);
        do_req(d, 1'b0, 8'h03, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst[d]        = 1'b1;
            valid[d]      = 1'b0;
            addr[d]       = 8'h0;
            wdata[d]      = 32'h0;
            be[d]         = 4'h0;
            wr[d]         = 1'b0;
            prev_rdy[d]   = 1'b0;
            last_rdy[d]   = -1;
            spacing_on[d] = 1'b0;
        end
        repeat (3) @(negedge clk);

        for (int d = 0; d < NDUT; d++) init_check(d);

        // Bank 0: latency, byte enables, no-op write, valid dropped after accept
        do_req(0, 1'b1, 8'h05, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
        do_req(0, 1'b0, 8'h05, 32'h0, 4'h0, 1'b0, 1'b0);
        do_req(0, 1'b1, 8'h07, 32'h1122_3344, 4'hF, 1'b1, 1'b0);
        do_req(0, 1'b1, 8'h07, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b0);
        do_req(0, 1'b0, 8'h07, 32'h0, 4'h0, 1'b0, 1'b0);
        do_req(0, 1'b1, 8'h07, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b0);
        do_req(0, 1'b0, 8'h07, 32'h0, 4'h0, 1'b0, 1'b0);
        do_req(0, 1'b1, 8'hFF, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1);
        do_req(0, 1'b0, 8'hFF, 32'h0, 4'h0, 1'b0, 1'b0);

        // Bank 1: out-of-range accesses and the top valid word
        do_req(1, 1'b1, 8'd210, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
        do_req(1, 1'b0, 8'd210, 32'h0, 4'h0, 1'b0, 1'b0);
        do_req(1, 1'b1, 8'd199, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b0);
        do_req(1, 1'b0, 8'd199, 32'h0, 4'h0, 1'b0, 1'b0);
        do_req(1, 1'b0, 8'd200, 32'h0, 4'h0, 1'b0, 1'b0);

        // Throughput with valid held: every 2 and every 5 cycles
        b2b_reads(1, 8);
        b2b_reads(2, 8);
        b2b_reads(0, 4);

        for (int d = 0; d < NDUT; d++) random_traffic(d, 60);

        reset_mid(0);

        repeat (4) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("sb_drained_d%0d", d), sb_q[d].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bank_ctrl.md
Name: mem_bank_ctrl

Overview:
Parametrised single-port synchronous memory bank with a valid/ready request handshake, per-byte write enables, programmable wait states and out-of-range error reporting. After reset it runs a hardware init sweep that clears every word before accepting traffic. It is the next-generation on-chip scratch/buffer memory behind a simple bus master or DMA engine.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of 8
DEPTH, 256, number of words implemented; 1 to 2**ADDR_WIDTH
ADDR_WIDTH, 8, word-address width
WAIT_CYCLES, 1, extra cycles inserted between accept and response; 0 to 15

Ports:
clk_i  input  1  clock; all logic on the rising edge
rst_i  input  1  asynchronous, active-high reset
addr_i  input  ADDR_WIDTH  word address of the request
wdata_i  input  WIDTH  write data
be_i  input  WIDTH/8  byte enables for writes; bit k enables wdata_i[8k+7:8k]; ignored on reads
wr_rd_i  input  1  1 = write, 0 = read
valid_i  input  1  request valid; held by the master until ready_o
ready_o  output  1  one-cycle response strobe; request completed
rdata_o  output  WIDTH  read data, valid when ready_o=1 for a read
err_o  output  1  response error flag, qualified by ready_o
init_done_o  output  1  1 once the init sweep has finished

Behaviour:
- Reset (async assert, sync deassert by the integrator): state=INIT, init counter=0, ready_o=0, err_o=0, rdata_o=0, init_done_o=0. Memory contents are not reset directly.
- States: INIT, IDLE, WAIT, RESP.
- INIT: writes 0 to mem[cnt] each cycle, cnt 0..DEPTH-1; after the write to DEPTH-1 -> IDLE and init_done_o=1 (stays 1 until next reset). Duration is exactly DEPTH cycles after reset release. valid_i is ignored; no ready_o.
- IDLE: if valid_i=1, capture addr_i, wdata_i, be_i and wr_rd_i into request registers. Go to WAIT if WAIT_CYCLES>0, otherwise RESP.
- WAIT: down-counter loaded with WAIT_CYCLES-1; -> RESP when counter is 0. Inputs are not resampled.
- RESP: ready_o=1 for exactly this cycle, then -> IDLE.
  - In range (addr < DEPTH), write: mem bytes with be=1 are updated at the end of RESP; bytes with be=0 are unchanged. rdata_o is unchanged. err_o=0.
  - In range, read: rdata_o = mem[addr], registered and presented in RESP. err_o=0.
  - Out of range (addr >= DEPTH): no memory access. Read returns rdata_o=0. err_o=1.
  - be_i=0 on a write is legal: a no-op write, err_o=0.
- Latency: request seen in IDLE at edge t gives ready_o high in cycle t+1+WAIT_CYCLES. Minimum spacing between accepts is 2+WAIT_CYCLES cycles; the master keeps valid_i high through the ready_o cycle, and the next request is sampled in the following IDLE cycle.
- rdata_o holds its last read value between read responses. err_o is cleared to 0 in every non-RESP cycle.
- valid_i dropped after accept (a protocol violation): the captured request still completes normally.
- Read immediately after a write to the same address returns the new data, because the write commits before the next IDLE.
- Reset mid-operation: any pending request is discarded, with no partial write and no ready_o. The block returns to INIT and the full sweep reruns.
- DEPTH = 2**ADDR_WIDTH: the out-of-range error is unreachable; the comparator may be optimised away.

Test Plan:
- Init: release reset, hold valid_i=1 -> ready_o stays 0 for 256 cycles; init_done_o rises at cycle 256; the first read of addr 0x10 returns 0x00000000 with err_o=0.
- Write/read latency with WAIT_CYCLES=1: write 0xDEADBEEF to 0x05 with be=4'hF -> ready_o 2 cycles after accept. Read 0x05 -> rdata_o=0xDEADBEEF with ready_o 2 cycles after accept.
- Byte enables: preload 0x11223344 at 0x07, then write 0xAABBCCDD with be=4'b0101 -> a read returns 0x11BB33DD.
- Out of range with DEPTH=200: write 0x12345678 to addr 210 -> ready_o=1, err_o=1, no memory change. Read addr 210 -> rdata_o=0, err_o=1. Read addr 199 -> err_o=0.
- WAIT_CYCLES=0 vs 3: back-to-back reads with valid_i held -> ready_o pulses every 2 and every 5 cycles respectively, each exactly 1 cycle wide.
- Reset mid-request: assert rst_i during WAIT of a write of 0xFFFFFFFF to 0x03 -> no ready_o, init_done_o=0, INIT reruns, and a later read of 0x03 returns 0.
